// File: rtl/fft_pkg.sv
// Shared Q8.8 types, constants and the rounding helper for the FFT datapath.
// FFT_TW_SAT_EN selects saturating results; otherwise results wrap to DW bits.
package fft_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned FRAC   = 8;
  localparam int unsigned ADDR_W = 5;

  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned RND_W  = SUM_W + 1;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  localparam logic [DW-1:0] ONE     = DW'(16'h0100);
  localparam logic [DW-1:0] NEG_ONE = DW'(16'hFF00);

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** (FRAC - 1));

  // Round half up, drop FRAC bits, then clamp or wrap back to DW bits.
  function automatic logic [DW-1:0] round_sat(input logic signed [SUM_W-1:0] sum);
`ifdef FFT_TW_SAT_EN
    logic signed [RND_W-1:0] shr;
    logic signed [RND_W-1:0] sat_hi;
    logic signed [RND_W-1:0] sat_lo;
    sat_hi = RND_W'(2 ** (DW - 1) - 1);
    sat_lo = RND_W'(-(2 ** (DW - 1)));
    shr    = (RND_W'(sum) + RND_HALF) >>> FRAC;
    if (shr > sat_hi) begin
      return DW'(sat_hi);
    end else if (shr < sat_lo) begin
      return DW'(sat_lo);
    end
    return DW'(shr);
`else
    return DW'((RND_W'(sum) + RND_HALF) >>> FRAC);
`endif
  endfunction

endpackage

// File: rtl/fft_cmul_pipe.sv
// Two-stage complex multiply: S2 registers the four partial products, S3 the
// rounded result. Both stages advance only while en is high.
module fft_cmul_pipe
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  smp_valid,
  input  logic  smp_sof,
  input  cplx_t smp,
  input  cplx_t tw,
  output logic  res_valid,
  output logic  res_sof,
  output cplx_t res
);

  logic signed [DW-1:0]     a, b, c, d;
  logic signed [PROD_W-1:0] p_ac, p_bd, p_ad, p_bc;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic                     s2_valid;
  logic                     s2_sof;

  always_comb begin
    a      = $signed(smp.re);
    b      = $signed(smp.im);
    c      = $signed(tw.re);
    d      = $signed(tw.im);
    sum_re = SUM_W'(p_ac) - SUM_W'(p_bd);
    sum_im = SUM_W'(p_ad) + SUM_W'(p_bc);
  end

  // S2: partial products; a bubble clears sof so it never leaks downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      p_ac     <= '0;
      p_bd     <= '0;
      p_ad     <= '0;
      p_bc     <= '0;
    end else if (en) begin
      s2_valid <= smp_valid;
      s2_sof   <= smp_valid & smp_sof;
      p_ac     <= PROD_W'(a) * PROD_W'(c);
      p_bd     <= PROD_W'(b) * PROD_W'(d);
      p_ad     <= PROD_W'(a) * PROD_W'(d);
      p_bc     <= PROD_W'(b) * PROD_W'(c);
    end
  end

  // S3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sof   <= 1'b0;
      res       <= '0;
    end else if (en) begin
      res_valid <= s2_valid;
      res_sof   <= s2_sof;
      res.re    <= round_sat(sum_re);
      res.im    <= round_sat(sum_im);
    end
  end

endmodule

// File: rtl/fft_twiddle_mult_stage.sv
// Twiddle-multiply stage of one FFT pass: sequences the twiddle ROM address
// and multiplies each sample by its twiddle. FFT_TW_SAT_EN enables saturation.
module fft_twiddle_mult_stage
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic [DW-1:0]     tw_re,
  input  logic [DW-1:0]     tw_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im
);

  localparam int unsigned       N_TW      = 28;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TW - 1);

  logic              pipe_en;
  logic              accept;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] use_addr;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_valid;
  logic              s1_sof;
  cplx_t             s1_smp;
  cplx_t             tw_cur;
  cplx_t             res;

  // While stalled the ROM is re-addressed with S1's entry so its data stays aligned.
  always_comb begin
    pipe_en  = out_ready | ~out_valid;
    accept   = in_valid & pipe_en;
    use_addr = in_sof ? '0 : addr_cnt;
    in_ready = pipe_en;
    tw_addr  = pipe_en ? ((in_valid & in_sof) ? '0 : addr_cnt) : s1_addr;
    tw_cur   = '{re: tw_re, im: tw_im};
    out_re   = res.re;
    out_im   = res.im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (accept) begin
      addr_cnt <= (use_addr == LAST_ADDR) ? '0 : use_addr + ADDR_W'(1);
    end
  end

  // S1: sample, sof and address; the ROM data for it arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_addr  <= '0;
      s1_smp   <= '0;
    end else if (pipe_en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sof  <= in_sof;
        s1_addr <= use_addr;
        s1_smp  <= '{re: in_re, im: in_im};
      end
    end
  end

  fft_cmul_pipe u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pipe_en),
    .smp_valid (s1_valid),
    .smp_sof   (s1_sof),
    .smp       (s1_smp),
    .tw        (tw_cur),
    .res_valid (out_valid),
    .res_sof   (out_sof),
    .res       (res)
  );

endmodule

// File: tb/tb_fft_twiddle_mult_stage.sv
// Randomised bench for fft_twiddle_mult_stage with a queue-based reference model.
module tb_fft_twiddle_mult_stage;
  import fft_pkg::*;

  localparam int unsigned N_TW = 28;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sof;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_sof;
  logic [DW-1:0]     in_re, in_im;
  logic [ADDR_W-1:0] tw_addr;
  logic [DW-1:0]     tw_re, tw_im;
  logic              out_valid, out_ready, out_sof;
  logic [DW-1:0]     out_re, out_im;

  logic [15:0] rom_re [0:31];
  logic [15:0] rom_im [0:31];

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   model_cnt = 0;
  int   sof_cnt   = 0;
  bit   any_acc   = 1'b0;
  logic exp_rdy;

  fft_twiddle_mult_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_addr   (tw_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  // Twiddle ROM pair with one-cycle registered read.
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdl_rnd(input longint s);
    longint r;
    r = (s + longint'(1 << (FRAC - 1))) >>> FRAC;
`ifdef FFT_TW_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  function automatic exp_t mdl(input logic [15:0] a, b, c, d, input logic sof);
    longint sa, sb, sc, sd;
    exp_t   e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    sd = longint'($signed(d));
    e.re  = mdl_rnd(sa * sc - sb * sd);
    e.im  = mdl_rnd(sa * sd + sb * sc);
    e.sof = sof;
    return e;
  endfunction

  // Compare process: model each accept and check each output handoff.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_rdy = out_ready | ~out_valid;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (!in_ready && any_acc)
        chk("stall_addr", 32'(tw_addr), 32'((model_cnt + N_TW - 1) % N_TW));
      if (in_valid && in_ready) begin
        int a;
        a = in_sof ? 0 : model_cnt;
        chk("acc_addr", 32'(tw_addr), 32'(a));
        q.push_back(mdl(in_re, in_im, rom_re[a], rom_im[a], in_sof));
        model_cnt = (a + 1) % N_TW;
        any_acc   = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_re", 32'(out_re), 32'(e.re));
          chk("out_im", 32'(out_im), 32'(e.im));
          chk("out_sof", 32'(out_sof), 32'(e.sof));
          if (out_sof) sof_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] re, input logic [15:0] im);
    in_valid = v;
    in_sof   = s;
    in_re    = re;
    in_im    = im;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_q", 32'(q.size()), 32'd0);
  endtask

  // mode 0: flowing, 1: five-cycle backpressure, 2: random valid/ready/sof.
  task automatic run(input int n, input int mode);
    int   sent;
    int   cyc;
    logic v, s;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 20 * n + 50) begin
      if (mode == 2) out_ready = ($urandom_range(0, 9) < 7);
      else           out_ready = !(mode == 1 && cyc >= 8 && cyc < 13);
      v = (mode == 2) ? ($urandom_range(0, 9) < 8) : 1'b1;
      s = (mode == 2) ? ($urandom_range(0, 19) == 0) : (sent == 0);
      drive(v, s, 16'($urandom), 16'($urandom));
      #1;
      if (v && in_ready) sent++;
      tick();
      cyc++;
    end
    chk("run_bound", 32'(sent), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sat_exp;
    for (int i = 0; i < 32; i++) begin
      rom_re[i] = 16'($urandom);
      rom_im[i] = 16'($urandom);
    end
    rom_re[0] = ONE;
    rom_im[0] = NEG_ONE;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_tw_addr", 32'(tw_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic multiply: (1 + 0.5j) * (1 - 1j) = 1.5 - 0.5j
    drive(1'b1, 1'b1, 16'h0100, 16'h0080);
    #1 chk("basic_addr", 32'(tw_addr), 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("basic_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("basic_lat2", 32'(out_valid), 32'd0);
    tick();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_re", 32'(out_re), 32'h0180);
    chk("basic_im", 32'(out_im), 32'hFF80);
    chk("basic_sof", 32'(out_sof), 32'd1);
    drain();

    // Overflow: real part is 2*0x7FFF in Q8.8.
`ifdef FFT_TW_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hFFFE;
`endif
    drive(1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_re", 32'(out_re), 32'(sat_exp));
    chk("sat_im", 32'(out_im), 32'h0000);
    drain();

    for (int i = 0; i < 32; i++) begin
      rom_re[i] = 16'($urandom);
      rom_im[i] = 16'($urandom);
    end

    // Address sequencing across the wrap.
    sof_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, i == 0, 16'($urandom), 16'($urandom));
      #1 chk("seq_addr", 32'(tw_addr), 32'(i % N_TW));
      tick();
    end
    drain();
    chk("seq_sof_count", 32'(sof_cnt), 32'd1);

    run(20, 1);
    drain();

    // Mid-frame sof at address 13.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, (i == 0) || (i == 13), 16'($urandom), 16'($urandom));
      #1;
      if (i == 13) chk("midsof_addr", 32'(tw_addr), 32'd0);
      if (i == 14) chk("midsof_next", 32'(tw_addr), 32'd1);
      tick();
    end
    drain();

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 16'($urandom), 16'($urandom));
      tick();
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    q.delete();
    model_cnt = 0;
    any_acc   = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_re", 32'(out_re), 32'd0);
    chk("midrst_im", 32'(out_im), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    #1 chk("postrst_addr", 32'(tw_addr), 32'd0);
    tick();
    drain();

    run(1200, 2);
    drain();
    run(40, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
